// File: rtl/mul_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// mul_pipe_ctrl
//
// Three-stage pipelined multiplier with a valid/ready wrapper. It sits between
// ALU issue and writeback.
//
//   S1 : captures the operands, extended to XLEN+1 bits, and the tag.
//   S2 : radix-4 Booth partial products and a 3:2 carry-save reduction tree,
//        registered as a sum/carry vector pair.
//   S3 : final carry-propagate add. This is the output register.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   flush       drops every in-flight operation; in_ready is low that cycle
//   in_valid    request valid
//   in_ready    a request can be accepted this cycle
//   in_src1     multiplicand (XLEN)
//   in_src2     multiplier (XLEN)
//   in_signed   1: signed x signed, 0: unsigned x unsigned
//   in_tag      opaque request tag (TAG_W)
//   out_valid   result valid (S3 occupied)
//   out_ready   consumer accepts the result
//   out_result  low 2*XLEN bits of the product
//   out_tag     tag of the returned result
//   busy        any stage occupied
//
// Each stage register loads only when its downstream slot is free or is being
// vacated in the same cycle. A full pipeline therefore streams one operation
// per cycle, does not insert bubbles, and holds its data stable while stalled.
// -----------------------------------------------------------------------------
module mul_pipe_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_src1,
  input  logic [XLEN-1:0]     in_src2,
  input  logic                in_signed,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*XLEN-1:0]   out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  // EW   : width of the extended operands.
  // PW   : width of the product.
  // NPP  : number of Booth digits needed to cover an EW-bit multiplier.
  // NROW : number of reduction rows, counting the NPP inputs plus two rows
  //        appended by each of the NPP-2 compressors.
  localparam int EW   = XLEN + 1;
  localparam int PW   = 2 * XLEN;
  localparam int NPP  = (XLEN + 2) / 2;
  localparam int NROW = 3 * NPP - 4;

  // ---------------------------------------------------------------------------
  // Handshake / advance control
  // ---------------------------------------------------------------------------
  logic v1, v2, v3;
  logic adv3, en3, en2, en1;
  logic in_fire;

  always_comb begin
    adv3     = v3 & out_ready;
    en3      = ~v3 | adv3;
    en2      = ~v2 | en3;
    en1      = ~v1 | en2;
    in_ready = en1 & ~flush;
    in_fire  = in_valid & in_ready;
  end

  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  // ---------------------------------------------------------------------------
  // Stage 1 registers: extended operands and tag
  // ---------------------------------------------------------------------------
  logic [EW-1:0]    a1, b1;
  logic [TAG_W-1:0] tag1;
  logic [EW-1:0]    a_in, b_in;

  // Zero extension makes the unsigned case a non-negative signed operand.
  // The signed EW x EW product then covers both modes.
  always_comb begin
    a_in = in_signed ? {in_src1[XLEN-1], in_src1} : {1'b0, in_src1};
    b_in = in_signed ? {in_src2[XLEN-1], in_src2} : {1'b0, in_src2};
  end

  // ---------------------------------------------------------------------------
  // Booth radix-4 partial products (combinational, from S1)
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  pp [NPP];
  logic [EW+1:0]  b_pad;
  logic [PW-1:0]  a_ext;

  always_comb begin
    logic [2:0]    sel;
    logic          one, two, neg;
    logic [PW-1:0] mag;
    sel = 3'b000;
    one = 1'b0;
    two = 1'b0;
    neg = 1'b0;
    mag = '0;
    // An implicit 0 sits below the LSB. The sign bit is repeated once so that
    // the top digit sees a complete triplet.
    b_pad = {b1[EW-1], b1, 1'b0};
    a_ext = {{(PW-EW){a1[EW-1]}}, a1};
    for (int i = 0; i < NPP; i++) begin
      sel = b_pad[2*i +: 3];
      // Digit = -2*b[2i+1] + b[2i] + b[2i-1], in {-2,-1,0,+1,+2}.
      one = sel[0] ^ sel[1];
      two = (sel == 3'b011) | (sel == 3'b100);
      neg = sel[2] & ~(sel[1] & sel[0]);
      mag = two ? (a_ext << 1) : (one ? a_ext : '0);
      pp[i] = (neg ? -mag : mag) << (2*i);
    end
  end

  // ---------------------------------------------------------------------------
  // Carry-save reduction tree
  //
  // The rows are treated as a FIFO. Each 3:2 compressor consumes the three
  // oldest rows and appends a sum row and a carry row. The carry row is
  // shifted one column left, so every column's carry feeds the next column.
  // Consuming the oldest rows first keeps the depth logarithmic, as in a
  // Wallace tree. After NPP-2 compressors, exactly two rows remain.
  // Everything is computed modulo 2^PW, so bits shifted out above PW are
  // dropped safely.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rows [NROW];
  logic [PW-1:0] tree_sum, tree_carry;

  always_comb begin
    logic [PW-1:0] x, y, z;
    x = '0;
    y = '0;
    z = '0;
    for (int k = 0; k < NROW; k++) rows[k] = '0;
    for (int k = 0; k < NPP; k++)  rows[k] = pp[k];
    for (int k = 0; k < NPP - 2; k++) begin
      x = rows[3*k];
      y = rows[3*k + 1];
      z = rows[3*k + 2];
      rows[NPP + 2*k]     = x ^ y ^ z;
      rows[NPP + 2*k + 1] = ((x & y) | (x & z) | (y & z)) << 1;
    end
    tree_sum   = rows[NROW-2];
    tree_carry = rows[NROW-1];
  end

  // ---------------------------------------------------------------------------
  // Stage 2 / stage 3 registers
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    sum2, carry2;
  logic [TAG_W-1:0] tag2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      a1         <= '0;
      b1         <= '0;
      tag1       <= '0;
      sum2       <= '0;
      carry2     <= '0;
      tag2       <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (flush) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else begin
        v1 <= in_fire | (v1 & ~en2);
        v2 <= (v1 & en2) | (v2 & ~en3);
        v3 <= (v2 & en3) | (v3 & ~adv3);
      end

      if (in_fire) begin
        a1   <= a_in;
        b1   <= b_in;
        tag1 <= in_tag;
      end

      // The data registers may still load during a flush. This is harmless,
      // because the valid bits clear in the same cycle.
      if (en2 && v1) begin
        sum2   <= tree_sum;
        carry2 <= tree_carry;
        tag2   <= tag1;
      end

      if (en3 && v2) begin
        out_result <= sum2 + carry2;
        out_tag    <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
module tb_mul_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_tag;
  logic        busy;

  mul_pipe_ctrl #(.XLEN(32), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_signed  (in_signed),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // One entry per accepted operation, in acceptance order.
  // stage = 1..3 is the pipeline slot the operation currently occupies.
  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
    int          stage;
  } ent_t;

  ent_t       q[$];
  logic [3:0] delivered[$];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge once the inputs are driven. The outputs are checked
  // against the model, and then the model advances across the next posedge.
  task automatic step();
    bit   exp_valid, deliver, exp_ready;
    int   lim, nxt;
    ent_t e;
    #1;
    exp_valid = (q.size() > 0) && (q[0].stage == 3);
    deliver   = exp_valid && out_ready;
    exp_ready = !flush && ((q.size() < 3) || deliver);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_valid);
    chk("busy", busy, q.size() > 0);
    if (exp_valid && out_valid === 1'b1) begin
      chk("out_result", out_result, q[0].res);
      chk("out_tag", out_tag, q[0].tag);
    end
    if (!rst && out_valid === 1'b1 && out_ready) delivered.push_back(out_tag);

    if (rst) begin
      q.delete();
    end else begin
      if (deliver) void'(q.pop_front());
      if (flush) begin
        q.delete();
      end else begin
        lim = 3;
        for (int i = 0; i < q.size(); i++) begin
          e   = q[i];
          nxt = e.stage + 1;
          if (nxt > lim) nxt = lim;
          e.stage = nxt;
          q[i]    = e;
          lim     = nxt - 1;
        end
        if (in_valid && exp_ready) begin
          e.res   = ref_mul(in_src1, in_src2, in_signed);
          e.tag   = in_tag;
          e.stage = 1;
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] t);
    in_valid  = 1'b1;
    in_src1   = a;
    in_src2   = b;
    in_signed = s;
    in_tag    = t;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic expect_out(input string name, input logic [63:0] res, input logic [3:0] t);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_result"}, out_result, res);
    chk({name, "_tag"}, out_tag, t);
  endtask

  logic [31:0] corner [6];

  initial begin
    logic [31:0] a, b;

    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_0001; corner[5] = 32'h5555_5555;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_src1 = '0; in_src2 = '0;
    in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", out_tag, 4'd0);

    // 1: latency and signed -1 x 2
    issue(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 4'd3);
    idle(1);
    chk("t1_not_early", out_valid, 1'b0);
    idle(1);
    expect_out("t1", 64'hFFFF_FFFF_FFFF_FFFE, 4'd3);
    idle(1);

    // 2: sign handling corners
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd4);
    idle(2);
    expect_out("t2_uu", 64'hFFFF_FFFE_0000_0001, 4'd4);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd5);
    idle(2);
    expect_out("t2_ss", 64'h0000_0000_0000_0001, 4'd5);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd6);
    idle(2);
    expect_out("t2_min", 64'h4000_0000_0000_0000, 4'd6);
    idle(1);

    // 3: back-to-back stream of 8
    delivered.delete();
    for (int i = 0; i < 8; i++)
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i));
    idle(3);
    chk("t3_count", delivered.size(), 8);
    for (int i = 0; i < delivered.size() && i < 8; i++)
      chk("t3_order", delivered[i], 4'(i));

    // 4: fill, stall, release
    out_ready = 1'b0;
    issue(32'd3, 32'd5, 1'b0, 4'd1);
    issue(32'd100, 32'd100, 1'b0, 4'd2);
    issue(32'hFFFF_FFFD, 32'd4, 1'b1, 4'd3);
    in_valid = 1'b1; in_tag = 4'd4;
    for (int i = 0; i < 5; i++) begin
      expect_out("t4_hold", 64'd15, 4'd1);
      chk("t4_in_ready", in_ready, 1'b0);
      step();
    end
    in_valid = 1'b0;
    delivered.delete();
    out_ready = 1'b1;
    idle(4);
    chk("t4_count", delivered.size(), 3);
    if (delivered.size() == 3) begin
      chk("t4_tag0", delivered[0], 4'd1);
      chk("t4_tag1", delivered[1], 4'd2);
      chk("t4_tag2", delivered[2], 4'd3);
    end

    // 5: flush with two in flight plus a simultaneous request
    delivered.delete();
    issue(32'd11, 32'd12, 1'b0, 4'd5);
    issue(32'd13, 32'd14, 1'b0, 4'd6);
    flush = 1'b1;
    issue(32'd15, 32'd16, 1'b0, 4'd9);
    flush = 1'b0;
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    idle(5);
    chk("t5_none_returned", delivered.size(), 0);

    // 6: reset with a full pipeline
    out_ready = 1'b0;
    issue(32'd1, 32'd2, 1'b0, 4'd10);
    issue(32'd3, 32'd4, 1'b0, 4'd11);
    issue(32'd5, 32'd6, 1'b0, 4'd12);
    in_valid = 1'b0;
    chk("t6_full", out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    issue(32'd7, 32'd6, 1'b0, 4'd2);
    idle(2);
    expect_out("t6", 64'd42, 4'd2);
    idle(1);

    // randomized traffic with backpressure, flush and reset
    for (int c = 0; c < 600; c++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      in_src1   = a;
      in_src2   = b;
      in_signed = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(5);
    chk("drain_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_pipe_ctrl.md
Name: mul_pipe_ctrl

Overview:
Pipeline controller and wrapper for the radix-4 Booth / 17-row Wallace multiplier datapath. It accepts 32-bit operand pairs over a valid/ready handshake and sequences them through three register stages: operand capture, Booth partial-product generation plus Wallace reduction, and final carry-propagate add. It returns the 64-bit product with a passthrough tag, supports output backpressure and a pipeline flush, and sits between the ALU issue logic and writeback.

Parameters:
XLEN, 32, operand width. Booth operands are sign- or zero-extended to XLEN+1 bits, giving 17 partial products at the default.
TAG_W, 4, width of the opaque request tag carried alongside each operation.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  kills every in-flight operation
in_valid  input  1  request valid
in_ready  output  1  controller can accept a request this cycle
in_src1  input  XLEN  multiplicand
in_src2  input  XLEN  multiplier
in_signed  input  1  1 = signed x signed, 0 = unsigned x unsigned
in_tag  input  TAG_W  request tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_result  output  2*XLEN  full product
out_tag  output  TAG_W  tag of the returned result
busy  output  1  any stage valid

Behaviour:
- Stages and valid bits:
  - S1 holds extended operands and tag (v1).
  - S2 holds Wallace sum/carry vectors and tag (v2).
  - S3 is the output register (v3, which drives out_valid).
- Reset: v1=v2=v3=0, so out_valid=0 and busy=0. out_result and out_tag reset to 0. in_ready=1 in the first cycle after reset releases.
- Advance rules, evaluated each cycle:
  - adv3 = v3 & out_ready
  - en3 = !v3 | adv3
  - en2 = !v2 | en3
  - en1 = !v1 | en2
  - in_ready = en1 & !flush
- Register updates:
  - in_fire = in_valid & in_ready.
  - S1 loads when in_fire. v1 <= in_fire | (v1 & !en2).
  - Each later stage loads the previous stage's data when its enable is high and the previous stage is valid. A valid bit clears when its contents move on and nothing replaces them.
- Latency and throughput:
  - A request fired in cycle T appears with out_valid=1 in cycle T+3 if out_ready stays high.
  - Sustained throughput is 1 operation per cycle.
  - A stalled stage holds its data stable. No bubble is inserted when the pipeline is full and out_ready toggles.
- Arithmetic:
  - src1/src2 are extended to XLEN+1 bits by in_signed (sign extend if 1, zero extend if 0).
  - Radix-4 Booth produces 17 partial products, reduced by the per-column 17-input CSA tree with the carry chain threaded column to column. The final add is in S3.
  - out_result = low 2*XLEN bits of the exact product. It is bit-exact to the signed (XLEN+1)x(XLEN+1) product.
- Output stability: while out_valid=1 and out_ready=0, out_result and out_tag must not change.
- Flush:
  - In the flush cycle, v1, v2 and v3 clear at the edge.
  - in_ready=0 during flush, so a simultaneous in_valid is dropped and never returns a result.
  - A result presented with out_valid=1 in the flush cycle counts as delivered only if out_ready=1 in that same cycle.
- Reset mid-operation: rst overrides flush and all handshakes. The state afterwards equals the post-reset state.
- busy = v1 | v2 | v3.
- The pipeline never reorders operations; tags return in acceptance order.

Test Plan:
1. Reset, then signed 0xFFFFFFFF x 0x00000002, tag 3, out_ready=1. Expect out_valid exactly 3 cycles after the fire, out_result=0xFFFFFFFFFFFFFFFE, out_tag=3.
2. Unsigned 0xFFFFFFFF x 0xFFFFFFFF. Expect 0xFFFFFFFE00000001. The same operands signed give 0x0000000000000001. Signed 0x80000000 x 0x80000000 gives 0x4000000000000000.
3. Back-to-back stream of 8 ops, tags 0..7, out_ready=1. Expect in_ready held at 1, eight consecutive out_valid cycles, tags 0..7 in order, every result matching a reference model.
4. Fill the pipeline with tags 1,2,3, then hold out_ready=0 for 5 cycles. Expect in_ready=0 once three ops are in flight, out_result/out_tag stable at tag 1. Release out_ready: tags 1,2,3 emerge on consecutive cycles.
5. Two ops in flight, then assert flush together with in_valid (tag 9). Expect out_valid=0 and busy=0 next cycle, and neither the in-flight tags nor tag 9 ever returned.
6. Assert rst for one cycle while v1, v2 and v3 are all 1. Expect out_valid=0, busy=0 and in_ready=1 after reset releases, and a subsequent op 7x6 returns 42.
